button_event_arbiter: RTL and testbench

BUTTON_EVENT_ARBITER -- requirements
Module: button_event_arbiter

---
 rtl/button_event_arbiter.sv | 144 ++++++++++++++
 tb/tb_button_event_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_arbiter.sv
// Button event arbiter: per-button press/release (and long-press when the
// LONG_PRESS_EN macro is defined) detection into pending flags, round-robin
// selection into a single valid/ready event register with a drop pulse.
module button_event_arbiter #(
  parameter int unsigned N_BTN     = 4,
  parameter int unsigned LONG_TIME = 27000000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_BTN-1:0]         btn_s,
  output logic                     ev_valid,
  input  logic                     ev_ready,
  output logic [$clog2(N_BTN)-1:0] ev_id,
  output logic [1:0]               ev_type,
  output logic                     ev_ovf
);

  localparam int unsigned ID_W     = $clog2(N_BTN);
  localparam logic [1:0]  EV_PRESS = 2'b01;
  localparam logic [1:0]  EV_REL   = 2'b10;
  localparam logic [1:0]  EV_LONG  = 2'b11;

  logic [N_BTN-1:0] btn_q;
  logic [N_BTN-1:0] pend_press, pend_long, pend_rel;
  logic [N_BTN-1:0] set_press, set_long, set_rel;
  logic [N_BTN-1:0] cons_press, cons_long, cons_rel;
  logic [N_BTN-1:0] any_pend, win_mask;
  logic [ID_W-1:0]  rr_ptr, win_id;
  logic [1:0]       win_type;
  logic             win_found, load, ovf_nxt;

  assign set_press = btn_s & ~btn_q;
  assign set_rel   = ~btn_s & btn_q;
  assign any_pend  = pend_press | pend_long | pend_rel;

  // Previous button level for edge detection; cleared so a held button re-presses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) btn_q <= '0;
    else        btn_q <= btn_s;
  end

`ifdef LONG_PRESS_EN
  localparam int unsigned     CNT_W    = $clog2(LONG_TIME);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(LONG_TIME - 1);
  localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'(LONG_TIME - 2);

  logic [CNT_W-1:0] hold_cnt [N_BTN];

  // Hold timer saturates at LONG_TIME-1, so the long event fires once per hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_BTN; i++) hold_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < N_BTN; i++) begin
        if (!btn_s[i])                  hold_cnt[i] <= '0;
        else if (hold_cnt[i] != CNT_MAX) hold_cnt[i] <= hold_cnt[i] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    set_long = '0;
    for (int unsigned i = 0; i < N_BTN; i++)
      set_long[i] = btn_s[i] && (hold_cnt[i] == CNT_FIRE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_long <= '0;
    else        pend_long <= set_long | (pend_long & ~cons_long);
  end
`else
  assign set_long  = '0;
  assign pend_long = '0;
`endif

  // Round-robin search starting at rr_ptr over buttons with any pending flag.
  always_comb begin
    int unsigned     idx;
    logic [ID_W-1:0] idx_b;
    idx       = 0;
    idx_b     = '0;
    win_found = 1'b0;
    win_id    = '0;
    for (int unsigned off = 0; off < N_BTN; off++) begin
      idx = 32'(rr_ptr) + off;
      if (idx >= N_BTN) idx = idx - N_BTN;
      idx_b = ID_W'(idx);
      if (!win_found && any_pend[idx_b]) begin
        win_found = 1'b1;
        win_id    = idx_b;
      end
    end
  end

  // Press before long before release within the winning button.
  always_comb begin
    win_type = EV_REL;
    if (pend_press[win_id])     win_type = EV_PRESS;
    else if (pend_long[win_id]) win_type = EV_LONG;
  end

  assign load       = win_found && (!ev_valid || ev_ready);
  assign win_mask   = load ? (N_BTN'(1) << win_id) : '0;
  assign cons_press = (win_type == EV_PRESS) ? win_mask : '0;
  assign cons_long  = (win_type == EV_LONG)  ? win_mask : '0;
  assign cons_rel   = (win_type == EV_REL)   ? win_mask : '0;

  // A set landing on a flag that is not being consumed this cycle is a drop.
  assign ovf_nxt = |((set_press & pend_press & ~cons_press) |
                     (set_long  & pend_long  & ~cons_long)  |
                     (set_rel   & pend_rel   & ~cons_rel));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_press <= '0;
      pend_rel   <= '0;
    end else begin
      pend_press <= set_press | (pend_press & ~cons_press);
      pend_rel   <= set_rel   | (pend_rel   & ~cons_rel);
    end
  end

  // Event slot: reload back-to-back on acceptance, hold while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ev_valid <= 1'b0;
      ev_id    <= '0;
      ev_type  <= '0;
      ev_ovf   <= 1'b0;
      rr_ptr   <= '0;
    end else begin
      ev_ovf <= ovf_nxt;
      if (load) begin
        ev_valid <= 1'b1;
        ev_id    <= win_id;
        ev_type  <= win_type;
        rr_ptr   <= (win_id == ID_W'(N_BTN - 1)) ? '0 : win_id + ID_W'(1);
      end else if (ev_ready) begin
        ev_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_button_event_arbiter.sv
// Bench for button_event_arbiter: directed scenarios with literal expectations
// plus randomized buttons/ready checked every cycle against an event-level model.
module tb_button_event_arbiter;

  localparam int N  = 4;
  localparam int LT = 8;
`ifdef LONG_PRESS_EN
  localparam bit LP_EN = 1'b1;
`else
  localparam bit LP_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] btn_s;
  logic         ev_ready;
  logic         ev_valid;
  logic [1:0]   ev_id;
  logic [1:0]   ev_type;
  logic         ev_ovf;

  int total = 0;
  int bad   = 0;

  button_event_arbiter #(.N_BTN(N), .LONG_TIME(LT)) dut (
    .clk(clk), .rst_n(rst_n), .btn_s(btn_s), .ev_valid(ev_valid),
    .ev_ready(ev_ready), .ev_id(ev_id), .ev_type(ev_type), .ev_ovf(ev_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int code_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 2);
  endfunction

  // Event-level model: pending sets per button (0 press, 1 long, 2 release).
  bit m_pend [N][3];
  bit m_prev [N];
  int m_run  [N];
  bit m_valid;
  int m_id, m_type, m_rr;
  bit m_ovf;

  always @(posedge clk or negedge rst_n) begin
    bit accept, freeslot, found, cons, ovf;
    bit setf [3];
    int w, wk, b;
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        for (int k = 0; k < 3; k++) m_pend[i][k] = 1'b0;
        m_prev[i] = 1'b0;
        m_run[i]  = 0;
      end
      m_valid = 1'b0; m_id = 0; m_type = 0; m_rr = 0; m_ovf = 1'b0;
    end else begin
      accept   = m_valid && ev_ready;
      freeslot = !m_valid || accept;
      found = 1'b0; w = 0; wk = 0;
      for (int off = 0; off < N; off++) begin
        b = (m_rr + off) % N;
        if (!found && (m_pend[b][0] || m_pend[b][1] || m_pend[b][2])) begin
          found = 1'b1;
          w = b;
        end
      end
      if (found) wk = m_pend[w][0] ? 0 : (m_pend[w][1] ? 1 : 2);
      ovf = 1'b0;
      for (int i = 0; i < N; i++) begin
        m_run[i] = btn_s[i] ? m_run[i] + 1 : 0;
        setf[0] = btn_s[i] && !m_prev[i];
        setf[1] = LP_EN && btn_s[i] && (m_run[i] == LT - 1);
        setf[2] = !btn_s[i] && m_prev[i];
        for (int k = 0; k < 3; k++) begin
          cons = found && freeslot && (w == i) && (wk == k);
          if (setf[k] && m_pend[i][k] && !cons) ovf = 1'b1;
          m_pend[i][k] = setf[k] || (m_pend[i][k] && !cons);
        end
        m_prev[i] = btn_s[i];
      end
      m_ovf = ovf;
      if (found && freeslot) begin
        m_valid = 1'b1; m_id = w; m_type = code_of(wk); m_rr = (w + 1) % N;
      end else if (accept) begin
        m_valid = 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    #1;
    chk("ev_valid", int'(ev_valid), int'(m_valid));
    chk("ev_ovf", int'(ev_ovf), int'(m_ovf));
    if (m_valid || !rst_n) begin
      chk("ev_id", int'(ev_id), m_id);
      chk("ev_type", int'(ev_type), m_type);
    end
  end

  // Accepted events (id*4+type) and drop pulses for the directed scenarios.
  int acc_q[$];
  int ovf_cnt;
  always @(negedge clk) begin
    #2;
    if (rst_n && ev_valid && ev_ready) acc_q.push_back(int'(ev_id) * 4 + int'(ev_type));
    if (ev_ovf) ovf_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_p, n_r, exp_n, a;
    int exp_seq [3];
    rst_n = 1'b0; btn_s = '0; ev_ready = 1'b0; ovf_cnt = 0;
    tick(3);
    chk("rst_valid", int'(ev_valid), 0);
    chk("rst_id", int'(ev_id), 0);
    chk("rst_type", int'(ev_type), 0);
    chk("rst_ovf", int'(ev_ovf), 0);
    rst_n = 1'b1;
    tick(2);

    // Single press: visible two cycles after the edge, gone one cycle later.
    ev_ready = 1'b1; btn_s[2] = 1'b1;
    tick(1); chk("t1_early_valid", int'(ev_valid), 0);
    tick(1); chk("t1_valid", int'(ev_valid), 1);
    chk("t1_id", int'(ev_id), 2);
    chk("t1_type", int'(ev_type), 1);
    tick(1); chk("t1_drop", int'(ev_valid), 0);
    btn_s[2] = 1'b0;
    tick(4);

    // Simultaneous presses on 0 and 3 go out back-to-back in round-robin order.
    do_reset();
    btn_s = 4'b1001;
    tick(1); chk("t2_early_valid", int'(ev_valid), 0);
    tick(1); chk("t2_first_id", int'(ev_id), 0);
    chk("t2_first_valid", int'(ev_valid), 1);
    tick(1); chk("t2_second_id", int'(ev_id), 3);
    chk("t2_second_valid", int'(ev_valid), 1);
    tick(1); chk("t2_idle", int'(ev_valid), 0);
    btn_s = '0;
    tick(5);

    // Stall: press held stable while release waits, then both in order.
    do_reset();
    ev_ready = 1'b0; btn_s[1] = 1'b1;
    tick(2); chk("t3_press_type", int'(ev_type), 1);
    chk("t3_press_id", int'(ev_id), 1);
    btn_s[1] = 1'b0;
    tick(3); chk("t3_hold_valid", int'(ev_valid), 1);
    chk("t3_hold_type", int'(ev_type), 1);
    ev_ready = 1'b1;
    tick(1); chk("t3_rel_type", int'(ev_type), 2);
    chk("t3_rel_id", int'(ev_id), 1);
    tick(1); chk("t3_idle", int'(ev_valid), 0);

    // Repeated press on btn 1 while its press flag is still pending.
    do_reset();
    ev_ready = 1'b0; ovf_cnt = 0; acc_q.delete();
    btn_s[0] = 1'b1;
    tick(2);
    btn_s[0] = 1'b0; btn_s[1] = 1'b1;
    tick(1); btn_s[1] = 1'b0;
    tick(1); btn_s[1] = 1'b1;
    tick(2);
    chk("t4_ovf_pulses", ovf_cnt, 1);
    ev_ready = 1'b1;
    tick(4);
    n_p = 0; n_r = 0;
    foreach (acc_q[i]) begin
      if (acc_q[i] == 5) n_p++;
      if (acc_q[i] == 6) n_r++;
    end
    chk("t4_first_event", (acc_q.size() > 0) ? acc_q[0] : -1, 1);
    chk("t4_btn1_presses", n_p, 1);
    chk("t4_btn1_releases", n_r, 1);
    chk("t4_ovf_total", ovf_cnt, 1);
    btn_s = '0;
    tick(6);

    // Long hold on btn 0.
    do_reset();
    ev_ready = 1'b1; acc_q.delete();
    btn_s[0] = 1'b1;
    tick(20);
    btn_s[0] = 1'b0;
    tick(5);
    exp_n = LP_EN ? 3 : 2;
    exp_seq[0] = 1;
    exp_seq[1] = LP_EN ? 3 : 2;
    exp_seq[2] = 2;
    chk("t5_event_count", acc_q.size(), exp_n);
    for (int i = 0; i < exp_n; i++) begin
      a = (i < acc_q.size()) ? acc_q[i] : -1;
      chk("t5_event_code", a, exp_seq[i]);
    end

    // Reset mid-handshake discards everything; a held button re-presses.
    do_reset();
    ev_ready = 1'b0; btn_s = 4'b1100;
    tick(2); chk("t6_pre_valid", int'(ev_valid), 1);
    chk("t6_pre_id", int'(ev_id), 2);
    rst_n = 1'b0; btn_s = 4'b1000;
    #1;
    chk("t6_rst_valid", int'(ev_valid), 0);
    chk("t6_rst_id", int'(ev_id), 0);
    chk("t6_rst_type", int'(ev_type), 0);
    chk("t6_rst_ovf", int'(ev_ovf), 0);
    tick(2);
    rst_n = 1'b1; ev_ready = 1'b1;
    tick(1); chk("t6_post_idle", int'(ev_valid), 0);
    tick(1); chk("t6_repress_id", int'(ev_id), 3);
    chk("t6_repress_type", int'(ev_type), 1);
    chk("t6_repress_valid", int'(ev_valid), 1);
    tick(1); chk("t6_no_stale", int'(ev_valid), 0);
    btn_s = '0;
    tick(5);

    // Randomized traffic, checked cycle by cycle against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 7) == 0) btn_s[i] = ~btn_s[i];
      ev_ready = ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 499) != 0);
      tick(1);
    end
    rst_n = 1'b1;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
